// File: rtl/qkv_attn_rd_scheduler_pkg.sv
// Shared definitions for the Q/K/V attention read scheduler.
//  - state_t : scheduler FSM encoding
//  - DEF_*   : default geometry constants
//  - idx_w() : index width for a count of n items (minimum 1 bit)
package qkv_attn_rd_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_QK       = 3'd2,
    ST_V        = 3'd3,
    ST_DRAIN    = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  localparam int unsigned DEF_ADDR_W     = 10;
  localparam int unsigned DEF_TILE_LINES = 32;
  localparam int unsigned DEF_Q_TILES    = 24;
  localparam int unsigned DEF_K_TILES    = 24;
  localparam int unsigned DEF_V_LINES    = 768;
  localparam int unsigned DEF_RD_LAT     = 1;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/qkv_attn_rd_scheduler_if.sv
// BRAM-address / PE-tag bundle between the read scheduler and the PE side.
//  master (scheduler): drives the three read addresses and the beat tags,
//                      receives i_pe_ready.
//  slave  (PE side)  : the mirror image.
interface qkv_attn_rd_scheduler_if
  import qkv_attn_rd_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned QIDX_W = idx_w(DEF_Q_TILES),
  parameter int unsigned KIDX_W = idx_w(DEF_K_TILES)
);
  logic              i_pe_ready;
  logic [ADDR_W-1:0] o_QueryRam_rdaddr;
  logic [ADDR_W-1:0] o_KeyRam_rdaddr;
  logic [ADDR_W-1:0] o_ValueRam_rdaddr;
  logic              o_qk_valid;
  logic              o_qk_last;
  logic [QIDX_W-1:0] o_qk_qidx;
  logic [KIDX_W-1:0] o_qk_kidx;
  logic              o_v_valid;
  logic              o_v_last;

  modport master (
    input  i_pe_ready,
    output o_QueryRam_rdaddr, o_KeyRam_rdaddr, o_ValueRam_rdaddr,
    output o_qk_valid, o_qk_last, o_qk_qidx, o_qk_kidx,
    output o_v_valid, o_v_last
  );

  modport slave (
    output i_pe_ready,
    input  o_QueryRam_rdaddr, o_KeyRam_rdaddr, o_ValueRam_rdaddr,
    input  o_qk_valid, o_qk_last, o_qk_qidx, o_qk_kidx,
    input  o_v_valid, o_v_last
  );
endinterface

// File: rtl/qkv_attn_rd_scheduler_tag_delay.sv
// attn_tag_delay: DEPTH-stage shift register with sync reset that delays the
// beat tag bundle so it lines up with the BRAM read data.
//  s_clk, s_rst : clock, sync active-high reset (flushes every stage)
//  i_d          : tag bundle in the issue cycle
//  o_q          : tag bundle DEPTH cycles later
module attn_tag_delay #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 1
) (
  input  logic         s_clk,
  input  logic         s_rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_pipe [DEPTH];

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_d;
      for (int i = 1; i < int'(DEPTH); i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];
endmodule

// File: rtl/qkv_attn_rd_scheduler.sv
// Read-side sequencer for the Q/K/V spike line BRAMs. Streams every
// (query tile, key tile) line pair, then every V line, with beat tags delayed
// by RD_LAT so they align with the BRAM outputs.
//  s_clk, s_rst         : clock, sync active-high reset
//  i_start              : start request, accepted only in IDLE
//  i_SpikesTmpRam_Ready : BRAMs filled, sampled only while waiting to begin
//  o_busy               : high from leaving IDLE through the DONE cycle
//  o_done               : one-cycle completion pulse
//  io_rd                : read addresses, beat tags, PE ready
module qkv_attn_rd_scheduler
  import qkv_attn_rd_scheduler_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned TILE_LINES = DEF_TILE_LINES,
  parameter int unsigned Q_TILES    = DEF_Q_TILES,
  parameter int unsigned K_TILES    = DEF_K_TILES,
  parameter int unsigned V_LINES    = DEF_V_LINES,
  parameter int unsigned RD_LAT     = DEF_RD_LAT
) (
  input  logic s_clk,
  input  logic s_rst,
  input  logic i_start,
  input  logic i_SpikesTmpRam_Ready,
  output logic o_busy,
  output logic o_done,
  qkv_attn_rd_scheduler_if.master io_rd
);
  localparam int unsigned L_W    = idx_w(TILE_LINES);
  localparam int unsigned QIDX_W = idx_w(Q_TILES);
  localparam int unsigned KIDX_W = idx_w(K_TILES);
  localparam int unsigned V_W    = idx_w(V_LINES);
  localparam int unsigned D_W    = idx_w(RD_LAT + 1);
  localparam int unsigned TAG_W  = 4 + QIDX_W + KIDX_W;

  state_t            r_state, w_state_nxt;
  logic [L_W-1:0]    r_l;
  logic [KIDX_W-1:0] r_kj;
  logic [QIDX_W-1:0] r_qi;
  logic [V_W-1:0]    r_v;
  logic [D_W-1:0]    r_drain;
  logic              r_start_lat;

  logic w_issue_qk, w_issue_v, w_lat_set, w_lat_clr;
  logic w_l_wrap, w_kj_wrap, w_qi_wrap, w_v_wrap, w_qk_end, w_drain_end;
  logic [TAG_W-1:0] w_tag_in, w_tag_out;

  assign w_l_wrap    = (r_l  == L_W'(TILE_LINES - 1));
  assign w_kj_wrap   = (r_kj == KIDX_W'(K_TILES - 1));
  assign w_qi_wrap   = (r_qi == QIDX_W'(Q_TILES - 1));
  assign w_v_wrap    = (r_v  == V_W'(V_LINES - 1));
  assign w_qk_end    = w_l_wrap & w_kj_wrap & w_qi_wrap;
  assign w_drain_end = (r_drain == D_W'(RD_LAT - 1));

  // State register
  always_ff @(posedge s_clk) begin
    if (s_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state and issue strobes
  always_comb begin
    w_state_nxt = r_state;
    w_issue_qk  = 1'b0;
    w_issue_v   = 1'b0;
    w_lat_set   = 1'b0;
    w_lat_clr   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_lat_set   = 1'b1;
          w_state_nxt = ST_WAIT_RDY;
        end
      end
      ST_WAIT_RDY: if (i_SpikesTmpRam_Ready) w_state_nxt = ST_QK;
      ST_QK: begin
        if (io_rd.i_pe_ready) begin
          w_issue_qk = 1'b1;
          if (w_qk_end) w_state_nxt = ST_V;
        end
      end
      ST_V: begin
        if (io_rd.i_pe_ready) begin
          w_issue_v = 1'b1;
          if (w_v_wrap) w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: if (w_drain_end) w_state_nxt = ST_DONE;
      ST_DONE: begin
        w_lat_clr   = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Line/tile/V counters advance only on issue; a completed run leaves them at 0
  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      r_l         <= '0;
      r_kj        <= '0;
      r_qi        <= '0;
      r_v         <= '0;
      r_drain     <= '0;
      r_start_lat <= 1'b0;
    end else begin
      if (w_issue_qk) begin
        r_l <= w_l_wrap ? '0 : r_l + L_W'(1);
        if (w_l_wrap) begin
          r_kj <= w_kj_wrap ? '0 : r_kj + KIDX_W'(1);
          if (w_kj_wrap) r_qi <= w_qi_wrap ? '0 : r_qi + QIDX_W'(1);
        end
      end
      if (w_issue_v) r_v <= w_v_wrap ? '0 : r_v + V_W'(1);
      if (r_state == ST_DRAIN) r_drain <= w_drain_end ? '0 : r_drain + D_W'(1);
      if (w_lat_set)      r_start_lat <= 1'b1;
      else if (w_lat_clr) r_start_lat <= 1'b0;
    end
  end

  // Addresses follow the counters in the issue cycle; the idle RAM reads 0
  assign io_rd.o_QueryRam_rdaddr = (r_state == ST_QK)
      ? ADDR_W'(ADDR_W'(r_qi) * ADDR_W'(TILE_LINES) + ADDR_W'(r_l)) : '0;
  assign io_rd.o_KeyRam_rdaddr   = (r_state == ST_QK)
      ? ADDR_W'(ADDR_W'(r_kj) * ADDR_W'(TILE_LINES) + ADDR_W'(r_l)) : '0;
  assign io_rd.o_ValueRam_rdaddr = (r_state == ST_V) ? ADDR_W'(r_v) : '0;

  assign w_tag_in = {w_issue_qk,
                     w_issue_qk & w_l_wrap,
                     w_issue_qk ? r_qi : '0,
                     w_issue_qk ? r_kj : '0,
                     w_issue_v,
                     w_issue_v & w_v_wrap};

  attn_tag_delay #(.W(TAG_W), .DEPTH(RD_LAT)) u_tag_delay (
    .s_clk (s_clk),
    .s_rst (s_rst),
    .i_d   (w_tag_in),
    .o_q   (w_tag_out)
  );

  assign {io_rd.o_qk_valid, io_rd.o_qk_last, io_rd.o_qk_qidx, io_rd.o_qk_kidx,
          io_rd.o_v_valid, io_rd.o_v_last} = w_tag_out;

  // The start latch is set exactly while the FSM is outside IDLE
  assign o_busy = r_start_lat;
  assign o_done = (r_state == ST_DONE);
endmodule

// File: tb/tb_qkv_attn_rd_scheduler.sv
// Scoreboard bench for qkv_attn_rd_scheduler on a small geometry
// (4 lines/tile, 2 query tiles, 3 key tiles, 8 V lines). A BRAM model delays
// the addresses by RD_LAT so each tagged beat is checked against the line it read.
module tb_qkv_attn_rd_scheduler;
  import qkv_attn_rd_scheduler_pkg::*;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned TL     = 4;
  localparam int unsigned QT     = 2;
  localparam int unsigned KT     = 3;
  localparam int unsigned VL     = 8;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned QW     = idx_w(QT);
  localparam int unsigned KW     = idx_w(KT);
  localparam int          NQK    = int'(QT * KT * TL);

  logic s_clk = 1'b0;
  logic s_rst = 1'b1;
  logic i_start = 1'b0;
  logic i_rdy = 1'b0;
  logic o_busy, o_done;

  qkv_attn_rd_scheduler_if #(.ADDR_W(ADDR_W), .QIDX_W(QW), .KIDX_W(KW)) rd_if ();

  qkv_attn_rd_scheduler #(
    .ADDR_W(ADDR_W), .TILE_LINES(TL), .Q_TILES(QT), .K_TILES(KT),
    .V_LINES(VL), .RD_LAT(RD_LAT)
  ) dut (
    .s_clk                (s_clk),
    .s_rst                (s_rst),
    .i_start              (i_start),
    .i_SpikesTmpRam_Ready (i_rdy),
    .o_busy               (o_busy),
    .o_done               (o_done),
    .io_rd                (rd_if)
  );

  always #5 s_clk = ~s_clk;

  typedef struct {
    int qa; int ka; int qi; int kj; int last;
  } qk_exp_t;

  qk_exp_t qk_q[$];
  int      v_q[$];

  int n_checks = 0;
  int n_errors = 0;
  int qk_cnt, v_cnt, qlast_cnt, vlast_cnt, done_cnt, cyc, vlast_cyc, done_cyc;
  int cap_qa[NQK];
  int cap_ka[NQK];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // BRAM model: read data equals the address presented RD_LAT cycles earlier
  logic [ADDR_W-1:0] qd [RD_LAT];
  logic [ADDR_W-1:0] kd [RD_LAT];
  logic [ADDR_W-1:0] vd [RD_LAT];
  always @(posedge s_clk) begin
    qd[0] <= rd_if.o_QueryRam_rdaddr;
    kd[0] <= rd_if.o_KeyRam_rdaddr;
    vd[0] <= rd_if.o_ValueRam_rdaddr;
    for (int i = 1; i < int'(RD_LAT); i++) begin
      qd[i] <= qd[i-1];
      kd[i] <= kd[i-1];
      vd[i] <= vd[i-1];
    end
  end

  // Monitor: pops expected beats whenever a valid tag is presented
  always @(negedge s_clk) begin
    cyc++;
    if (!s_rst) begin
      if (rd_if.o_qk_valid) begin
        longint act;
        act = longint'(qd[RD_LAT-1]) * 10000000 + longint'(kd[RD_LAT-1]) * 10000
            + longint'(rd_if.o_qk_qidx) * 100 + longint'(rd_if.o_qk_kidx) * 10
            + longint'(rd_if.o_qk_last);
        if (qk_q.size() == 0) begin
          chk("qk_unexpected_beat", act, -1);
        end else begin
          qk_exp_t e;
          e = qk_q.pop_front();
          chk("qk_beat", act, longint'(e.qa) * 10000000 + longint'(e.ka) * 10000
                              + longint'(e.qi) * 100 + longint'(e.kj) * 10 + longint'(e.last));
        end
        if (qk_cnt < NQK) begin
          cap_qa[qk_cnt] = int'(qd[RD_LAT-1]);
          cap_ka[qk_cnt] = int'(kd[RD_LAT-1]);
        end
        qk_cnt++;
        if (rd_if.o_qk_last) qlast_cnt++;
      end
      if (rd_if.o_v_valid) begin
        longint act;
        act = longint'(vd[RD_LAT-1]) * 10 + longint'(rd_if.o_v_last);
        if (v_q.size() == 0) begin
          chk("v_unexpected_beat", act, -1);
        end else begin
          int e;
          e = v_q.pop_front();
          chk("v_beat", act, longint'(e) * 10 + ((e == int'(VL) - 1) ? 1 : 0));
        end
        v_cnt++;
        if (rd_if.o_v_last) begin
          vlast_cnt++;
          vlast_cyc = cyc;
        end
      end
      if (o_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic clear_stats();
    qk_cnt = 0; v_cnt = 0; qlast_cnt = 0; vlast_cnt = 0; done_cnt = 0;
    vlast_cyc = 0; done_cyc = 0;
    for (int i = 0; i < NQK; i++) begin
      cap_qa[i] = -1;
      cap_ka[i] = -1;
    end
  endtask

  task automatic push_exp();
    for (int qi = 0; qi < int'(QT); qi++)
      for (int kj = 0; kj < int'(KT); kj++)
        for (int l = 0; l < int'(TL); l++)
          qk_q.push_back('{qi * int'(TL) + l, kj * int'(TL) + l, qi, kj,
                           (l == int'(TL) - 1) ? 1 : 0});
    for (int v = 0; v < int'(VL); v++) v_q.push_back(v);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(posedge s_clk); #1;
    i_start = 1'b0;
  endtask

  // Waits for o_done, optionally randomising i_pe_ready every cycle
  task automatic wait_done(input string nm, input bit rnd);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 2000 && !seen; n++) begin
      @(posedge s_clk); #1;
      if (o_done) begin
        seen = 1'b1;
        chk({nm, "_busy_in_done"}, longint'(o_busy), 1);
      end
      if (rnd) rd_if.i_pe_ready = 1'($urandom_range(0, 1));
    end
    rd_if.i_pe_ready = 1'b1;
    if (!seen) chk({nm, "_done_timeout"}, 0, 1);
  endtask

  task automatic end_checks(input string nm);
    repeat (3) @(posedge s_clk);
    #1;
    chk({nm, "_qk_beats"},  qk_cnt, NQK);
    chk({nm, "_v_beats"},   v_cnt, int'(VL));
    chk({nm, "_qk_lasts"},  qlast_cnt, int'(QT * KT));
    chk({nm, "_v_lasts"},   vlast_cnt, 1);
    chk({nm, "_dones"},     done_cnt, 1);
    chk({nm, "_vlast_to_done"}, done_cyc - vlast_cyc, 1);
    chk({nm, "_qk_left"},   qk_q.size(), 0);
    chk({nm, "_v_left"},    v_q.size(), 0);
    chk({nm, "_busy_after"}, longint'(o_busy), 0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_qk_valid"}, longint'(rd_if.o_qk_valid), 0);
    chk({nm, "_qk_last"},  longint'(rd_if.o_qk_last), 0);
    chk({nm, "_v_valid"},  longint'(rd_if.o_v_valid), 0);
    chk({nm, "_v_last"},   longint'(rd_if.o_v_last), 0);
    chk({nm, "_qaddr"},    longint'(rd_if.o_QueryRam_rdaddr), 0);
    chk({nm, "_kaddr"},    longint'(rd_if.o_KeyRam_rdaddr), 0);
    chk({nm, "_vaddr"},    longint'(rd_if.o_ValueRam_rdaddr), 0);
    chk({nm, "_busy"},     longint'(o_busy), 0);
    chk({nm, "_done"},     longint'(o_done), 0);
  endtask

  initial begin
    rd_if.i_pe_ready = 1'b1;
    clear_stats();
    repeat (3) @(posedge s_clk);
    #1;
    chk_all_zero("reset");
    s_rst = 1'b0;

    // Full run, ready already high, PE always ready
    i_rdy = 1'b1;
    clear_stats();
    push_exp();
    pulse_start();
    wait_done("run1", 1'b0);
    end_checks("run1");
    chk("run1_kj1_beat0_q", cap_qa[4], 0);
    chk("run1_kj1_beat0_k", cap_ka[4], 4);
    chk("run1_beat13_q",    cap_qa[13], 5);
    chk("run1_beat13_k",    cap_ka[13], 1);
    chk("run1_last_q",      cap_qa[NQK-1], 7);
    chk("run1_last_k",      cap_ka[NQK-1], 11);

    // Start while BRAMs are not ready: nothing issues until Ready rises
    i_rdy = 1'b0;
    clear_stats();
    push_exp();
    pulse_start();
    repeat (20) @(posedge s_clk);
    #1;
    chk("nordy_busy",    longint'(o_busy), 1);
    chk("nordy_qk_cnt",  qk_cnt, 0);
    i_rdy = 1'b1;
    begin
      int lat;
      lat = 0;
      for (int n = 1; n <= 50 && lat == 0; n++) begin
        @(posedge s_clk); #1;
        i_rdy = 1'b0;
        if (rd_if.o_qk_valid) lat = n;
      end
      chk("rdy_to_first_valid", lat, 1 + int'(RD_LAT));
    end
    wait_done("late_rdy", 1'b0);
    end_checks("late_rdy");
    i_rdy = 1'b1;

    // Random PE backpressure
    clear_stats();
    push_exp();
    pulse_start();
    wait_done("rand", 1'b1);
    end_checks("rand");

    // Reset in the middle of the QK phase
    clear_stats();
    push_exp();
    pulse_start();
    for (int n = 0; n < 200 && qk_cnt < 10; n++) begin
      @(posedge s_clk); #1;
    end
    chk("midrst_reached_beat10", longint'(qk_cnt >= 10), 1);
    s_rst = 1'b1;
    @(posedge s_clk); #1;
    chk_all_zero("midrst");
    s_rst = 1'b0;
    qk_q.delete();
    v_q.delete();
    clear_stats();
    repeat (4) @(posedge s_clk);
    #1;
    chk("midrst_quiet_busy", longint'(o_busy), 0);
    push_exp();
    pulse_start();
    wait_done("after_rst", 1'b0);
    end_checks("after_rst");
    chk("after_rst_first_q", cap_qa[0], 0);
    chk("after_rst_first_k", cap_ka[0], 0);

    // Start held high through the run and the DONE cycle
    clear_stats();
    push_exp();
    i_start = 1'b1;
    wait_done("held_start", 1'b0);
    @(posedge s_clk); #1;
    i_start = 1'b0;
    repeat (10) @(posedge s_clk);
    #1;
    end_checks("held_start");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
